// File: rtl/two_neuron_pkg.sv
// Shared definitions for the two-neuron datapath: sentinel encoding, collector states, idle test.
package two_neuron_pkg;

    localparam int unsigned DEF_AW  = 3;
    localparam int unsigned DEF_S   = 8;
    localparam int unsigned DEF_W   = 16;
    localparam int unsigned DEF_LAT = 1;

    // Address value carrying "no result this cycle" (MSB set, index bits clear)
    localparam logic [DEF_AW:0] SENTINEL = {1'b1, {DEF_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // An address with its MSB set carries no result
    function automatic logic is_idle(input logic [DEF_AW:0] addr);
        return addr[DEF_AW];
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Sequencer/host-side bus of the result collector: address/result streams in, readout and status out.
interface result_collector_if #(
    parameter int unsigned AW = two_neuron_pkg::DEF_AW,
    parameter int unsigned W  = two_neuron_pkg::DEF_W
);
    logic          start;
    logic [AW:0]   addr_r_in;
    logic [AW:0]   addr_c_in;
    logic [W-1:0]  y_r;
    logic [W-1:0]  y_c;
    logic          rd_en;
    logic          rd_sel;
    logic [AW-1:0] rd_idx;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          done;
    logic          err;

    modport master (
        output start, addr_r_in, addr_c_in, y_r, y_c, rd_en, rd_sel, rd_idx,
        input  rd_data, rd_valid, done, err
    );

    modport slave (
        input  start, addr_r_in, addr_c_in, y_r, y_c, rd_en, rd_sel, rd_idx,
        output rd_data, rd_valid, done, err
    );
endinterface

// File: rtl/addr_delay_line.sv
// Realigns a sentinel-tagged address stream to the neuron output latency (LAT=0 is a wire).
module addr_delay_line #(
    parameter int unsigned AW  = 3,
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_flush,
    input  logic [AW:0] i_addr,
    output logic [AW:0] o_addr
);
    localparam logic [AW:0] L_SENT = {1'b1, {AW{1'b0}}};

    generate
        if (LAT == 0) begin : g_wire
            assign o_addr = i_addr;
        end else begin : g_chain
            logic [AW:0] r_stage [LAT];

            // Shift chain; reset and flush both refill every stage with the sentinel
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT; i++) r_stage[i] <= L_SENT;
                end else if (i_flush) begin
                    for (int i = 0; i < LAT; i++) r_stage[i] <= L_SENT;
                end else begin
                    r_stage[0] <= i_addr;
                    for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_addr = r_stage[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/result_collector.sv
// Write-back end of the two-neuron datapath: stores delayed R/C results, flags completion, serves readout.
// Optional build macro COLLECT_RELU_EN: clamp negative results to zero as they are stored.
module result_collector
    import two_neuron_pkg::*;
#(
    parameter int unsigned S   = DEF_S,
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned W   = DEF_W,
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic               clk,
    input  logic               reset_n,
    result_collector_if.slave  bus
);
    localparam int unsigned CW = $clog2(S + 1);

    state_t        r_state, w_state_next;
    logic          r_done, r_err, r_rd_valid;
    logic [W-1:0]  r_rd_data;
    logic [S-1:0]  r_mask_r, r_mask_c;
    logic [CW-1:0] r_cnt_r, r_cnt_c;
    logic [W-1:0]  r_bank_r [S];
    logic [W-1:0]  r_bank_c [S];

    logic [AW:0]   w_addr_r_dly, w_addr_c_dly;
    logic [AW-1:0] w_idx_r, w_idx_c;
    logic [W-1:0]  w_y_r_st, w_y_c_st;
    logic          w_collect, w_hit_r, w_hit_c, w_oor_r, w_oor_c, w_dup_r, w_dup_c;
    logic          w_rd_acc, w_rd_oor;

    addr_delay_line #(.AW(AW), .LAT(LAT)) u_dly_r (
        .clk(clk), .reset_n(reset_n), .i_flush(bus.start),
        .i_addr(bus.addr_r_in), .o_addr(w_addr_r_dly)
    );

    addr_delay_line #(.AW(AW), .LAT(LAT)) u_dly_c (
        .clk(clk), .reset_n(reset_n), .i_flush(bus.start),
        .i_addr(bus.addr_c_in), .o_addr(w_addr_c_dly)
    );

`ifdef COLLECT_RELU_EN
    assign w_y_r_st = bus.y_r[W-1] ? '0 : bus.y_r;
    assign w_y_c_st = bus.y_c[W-1] ? '0 : bus.y_c;
`else
    assign w_y_r_st = bus.y_r;
    assign w_y_c_st = bus.y_c;
`endif

    // Write decode on the delayed addresses; start suppresses any write in its cycle
    assign w_collect = (r_state == ST_COLLECT) && !bus.start;
    assign w_idx_r   = w_addr_r_dly[AW-1:0];
    assign w_idx_c   = w_addr_c_dly[AW-1:0];
    assign w_hit_r   = w_collect && !is_idle(w_addr_r_dly) && (32'(w_idx_r) < S);
    assign w_hit_c   = w_collect && !is_idle(w_addr_c_dly) && (32'(w_idx_c) < S);
    assign w_oor_r   = w_collect && !is_idle(w_addr_r_dly) && !(32'(w_idx_r) < S);
    assign w_oor_c   = w_collect && !is_idle(w_addr_c_dly) && !(32'(w_idx_c) < S);
    assign w_dup_r   = w_hit_r && r_mask_r[w_idx_r];
    assign w_dup_c   = w_hit_c && r_mask_c[w_idx_c];

    assign w_rd_acc  = bus.rd_en && (r_state == ST_DONE) && !bus.start;
    assign w_rd_oor  = (32'(bus.rd_idx) >= S);

    // State register; done mirrors the registered DONE state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Next-state: start always (re)enters COLLECT; full masks on both banks finish the pass
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.start) w_state_next = ST_COLLECT;
            ST_COLLECT: begin
                if (bus.start)
                    w_state_next = ST_COLLECT;
                else if ((r_cnt_r == CW'(S)) && (r_cnt_c == CW'(S)))
                    w_state_next = ST_DONE;
            end
            ST_DONE:    if (bus.start) w_state_next = ST_COLLECT;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Result storage (no reset: every entry is written before it can be read in DONE)
    always_ff @(posedge clk) begin
        if (w_hit_r) r_bank_r[w_idx_r] <= w_y_r_st;
        if (w_hit_c) r_bank_c[w_idx_c] <= w_y_c_st;
    end

    // Valid masks, distinct-write counters and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask_r <= '0;
            r_mask_c <= '0;
            r_cnt_r  <= '0;
            r_cnt_c  <= '0;
            r_err    <= 1'b0;
        end else if (bus.start) begin
            r_mask_r <= '0;
            r_mask_c <= '0;
            r_cnt_r  <= '0;
            r_cnt_c  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_hit_r && !w_dup_r) begin
                r_mask_r[w_idx_r] <= 1'b1;
                r_cnt_r           <= r_cnt_r + CW'(1);
            end
            if (w_hit_c && !w_dup_c) begin
                r_mask_c[w_idx_c] <= 1'b1;
                r_cnt_c           <= r_cnt_c + CW'(1);
            end
            if (w_dup_r || w_dup_c || w_oor_r || w_oor_c || (w_rd_acc && w_rd_oor))
                r_err <= 1'b1;
        end
    end

    // Registered read port; data holds when no read is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                if (w_rd_oor)
                    r_rd_data <= '0;
                else
                    r_rd_data <= bus.rd_sel ? r_bank_c[bus.rd_idx] : r_bank_r[bus.rd_idx];
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule
